// File: rtl/mul_unit.sv
// mul_unit: iterative 32x32 multiplier that owns the HI/LO register pair.
//
// Purpose:
//   A multiply starts on START from IDLE. It runs WIDTH radix-2 shift-add steps
//   on operand magnitudes, then applies the sign in a single FIX cycle.
//   HI/LO can be read through a combinational mux. They can be written
//   (MTHI/MTLO) only while idle. STALL tells the pipeline to hold any HI/LO
//   access while a multiply is in flight.
//
// Ports:
//   i_clk      clock; all state updates on the rising edge
//   i_reset    synchronous, active-high reset
//   i_start    begin a multiply (sampled only in IDLE)
//   i_signed   1 = MULT (two's complement), 0 = MULTU; sampled with i_start
//   i_a, i_b   multiplicand / multiplier; sampled with i_start
//   i_rd_req   MFHI/MFLO access this cycle
//   i_rd_sel   1 = HI, 0 = LO
//   o_rd_data  selected HI/LO register (combinational)
//   i_wr_en    MTHI/MTLO write
//   i_wr_sel   1 = HI, 0 = LO
//   i_wr_data  write data
//   o_busy     multiply in progress
//   o_done     one-cycle pulse after HI/LO take a product
//   o_stall    (i_rd_req | i_wr_en) & o_busy
module mul_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_rd_req,
    input  logic             i_rd_sel,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_wr_en,
    input  logic             i_wr_sel,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_hi, r_lo;
    logic [WIDTH-1:0]     r_mcand, r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_done;

    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_fix;

    // Magnitudes are unsigned WIDTH-bit values, so the most negative input
    // negates to itself and is still the correct magnitude.
    assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
    assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;

    // Upper-half add keeps its carry, and that carry becomes the new MSB
    // after the shift. After WIDTH steps, r_acc holds the full product.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    assign w_fix     = r_neg ? (~r_acc + 1'b1) : r_acc;

    assign o_busy    = (r_state != S_IDLE);
    assign o_stall   = (i_rd_req | i_wr_en) & o_busy;
    assign o_rd_data = i_rd_sel ? r_hi : r_lo;
    assign o_done    = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST_STEP) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    // START takes priority; a coincident write is dropped.
                    if (i_start) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else if (i_wr_en) begin
                        if (i_wr_sel) r_hi <= i_wr_data;
                        else          r_lo <= i_wr_data;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    {r_hi, r_lo} <= w_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit. Inputs change and outputs are sampled on the
// falling clock edge. Expected values are hand-computed constants.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset, start, sgn, rd_req, rd_sel, wr_en, wr_sel;
    logic [31:0] a, b, wr_data, rd_data;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;

    mul_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (start),
        .i_signed (sgn),
        .i_a      (a),
        .i_b      (b),
        .i_rd_req (rd_req),
        .i_rd_sel (rd_sel),
        .o_rd_data(rd_data),
        .i_wr_en  (wr_en),
        .i_wr_sel (wr_sel),
        .i_wr_data(wr_data),
        .o_busy   (busy),
        .o_done   (done),
        .o_stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic sel, output logic [31:0] d);
        rd_sel = sel;
        #1;
        d = rd_data;
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] d;
        rd(1'b1, d); chk({tag, "_hi"}, d, hi);
        rd(1'b0, d); chk({tag, "_lo"}, d, lo);
    endtask

    // kind: 0 none, 1 hold HI read from cycle `at`, 2 second START at `at`,
    //       3 HI write at `at`, 4 reset at `at`, 5 write together with START.
    // Returns the cycle (counted from the START cycle) at which DONE was seen
    // (0 if never), and the number of cycles that BUSY was high.
    task automatic do_mul(input logic [31:0] ia, ib, input logic is, input int kind,
                          input int at, output int lat, output int bcnt);
        int n;
        logic [31:0] d;
        lat = 0; bcnt = 0; n = 0;
        a = ia; b = ib; sgn = is; start = 1'b1;
        if (kind == 5) begin wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'h5555_5555; end
        while (n < 45 && lat == 0) begin
            @(negedge clk);
            n++;
            start = 1'b0; wr_en = 1'b0; reset = 1'b0;
            a = 32'h0; b = 32'h0;
            if (busy) bcnt++;
            if (done) lat = n;
            if (kind == 1 && n > at) chk("stall_rd", stall, busy);
            if (kind == 4 && n == at + 1) begin
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk_hilo("rst", 32'h0, 32'h0);
            end
            if (n == at) begin
                case (kind)
                    1: begin rd_req = 1'b1; rd_sel = 1'b1; end
                    2: begin start = 1'b1; a = 32'd9; b = 32'd9; end
                    3: begin
                        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'hAAAA_AAAA;
                        #1 chk("stall_wr", stall, 1'b1);
                    end
                    4: reset = 1'b1;
                    default: ;
                endcase
            end
        end
        if (kind == 1) begin
            rd(1'b1, d);
            chk("rd_after_done", {stall, d}, {1'b0, 32'h0000_0003});
        end
        rd_req = 1'b0;
        if (lat != 0) begin
            @(negedge clk);
            chk("done_pulse_end", done, 1'b0);
        end
    endtask

    initial begin
        int lat, bcnt;
        logic [31:0] d;
        reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        rd_req = 1'b0; rd_sel = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_state", {busy, done, stall}, 3'b000);
        chk_hilo("rst0", 32'h0, 32'h0);

        // 7 x 6 unsigned, with latency and busy length
        do_mul(32'd7, 32'd6, 1'b0, 0, 0, lat, bcnt);
        chk("lat_7x6", lat, 34);
        chk("busy_7x6", bcnt, 33);
        chk_hilo("7x6", 32'h0, 32'h0000_002A);

        do_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, lat, bcnt);
        chk_hilo("m3x5_s", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_mul(32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, lat, bcnt);
        chk_hilo("m3x5_u", 32'h0000_0004, 32'hFFFF_FFF1);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, lat, bcnt);
        chk_hilo("ffxff_u", 32'hFFFF_FFFE, 32'h0000_0001);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, lat, bcnt);
        chk_hilo("min_sq", 32'h4000_0000, 32'h0);
        do_mul(32'h8000_0000, 32'd1, 1'b1, 0, 0, lat, bcnt);
        chk_hilo("min_x1", 32'hFFFF_FFFF, 32'h8000_0000);

        // HI read held from cycle 10: stalled while busy, new HI after DONE
        do_mul(32'h0001_0000, 32'h0003_0000, 1'b0, 1, 10, lat, bcnt);
        chk("lat_rd", lat, 34);

        // second START ignored
        do_mul(32'd100, 32'd200, 1'b0, 2, 5, lat, bcnt);
        chk("lat_2nd", lat, 34);
        chk_hilo("2nd_start", 32'h0, 32'h0000_4E20);

        // write while busy dropped
        do_mul(32'h10, 32'h10, 1'b0, 3, 10, lat, bcnt);
        chk_hilo("wr_busy", 32'h0, 32'h0000_0100);

        // idle writes
        wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h1234_5678;
        @(negedge clk);
        wr_en = 1'b0;
        chk_hilo("wr_lo", 32'h0, 32'h1234_5678);
        wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_en = 1'b0;
        chk_hilo("wr_hi", 32'hDEAD_BEEF, 32'h1234_5678);

        // START + WR_EN together: product wins
        do_mul(32'd3, 32'd4, 1'b0, 5, 0, lat, bcnt);
        chk_hilo("start_wr", 32'h0, 32'h0000_000C);

        // reset mid-run: no DONE, then a clean multiply
        do_mul(32'd5, 32'd7, 1'b0, 4, 15, lat, bcnt);
        chk("rst_no_done", lat, 0);
        do_mul(32'd2, 32'd3, 1'b0, 0, 0, lat, bcnt);
        chk("lat_2x3", lat, 34);
        rd(1'b0, d);
        chk("2x3_lo", d, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative 32x32 multiplier with the HI/LO register pair.
- It is the execute-side responder for the controller's multiply-group control bits.
- It starts on MULT/MULTU, serves MFHI/MFLO reads, and accepts MTHI/MTLO writes.
- It asserts STALL so the pipeline holds a HI/LO access while a multiply is still in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin a multiply; sampled only while in IDLE.
- SIGNED  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with START.
- A  in  WIDTH  multiplicand (rs); sampled with START.
- B  in  WIDTH  multiplier (rt); sampled with START.
- RD_REQ  in  1  MFHI/MFLO access in the current cycle.
- RD_SEL  in  1  1 = HI, 0 = LO.
- RD_DATA  out  WIDTH  combinational mux of the HI/LO registers selected by RD_SEL.
- WR_EN  in  1  MTHI/MTLO write.
- WR_SEL  in  1  1 = HI, 0 = LO.
- WR_DATA  in  WIDTH  write data.
- BUSY  out  1  multiply in progress.
- DONE  out  1  one-cycle pulse when HI/LO receive a product.
- STALL  out  1  (RD_REQ | WR_EN) & BUSY.

Behaviour:
- Reset: RESET=1 at an edge forces state IDLE, HI=0, LO=0, counter=0, internal accumulator and operands 0, DONE=0. This holds in any state and aborts an in-flight multiply with no HI/LO update. BUSY=0 and STALL=0 follow from IDLE.
- States: IDLE, RUN, FIX. BUSY = (state != IDLE), registered-state decode.
- IDLE, START=1 at edge E0:
  - Latch magnitudes: |A| and |B| if SIGNED, else raw A and B.
  - Latch neg = SIGNED & (A[31]^B[31]).
  - Clear the 2*WIDTH accumulator; counter=0; go to RUN.
  - 0x80000000 has magnitude 0x80000000 and is treated as an unsigned WIDTH-bit value.
- RUN: one radix-2 shift-add step per edge, LSB-first over the multiplier: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator with carry-out kept; then shift right by 1. The counter increments each step. When counter==WIDTH-1 the step executes and the state goes to FIX. RUN therefore occupies exactly WIDTH edges (E1..E32).
- FIX at edge E33: {HI,LO} <= neg ? -acc (2*WIDTH two's-complement) : acc. DONE=1 in the cycle after E33, then 0. State returns to IDLE.
- Latency: BUSY high after E0 through E33 (33 cycles). A read issued in the cycle after E33 returns the new product. There is no forwarding of partial results.
- START while BUSY is ignored; the pipeline stalls it via its own hazard logic. START is not queued.
- Reads: RD_DATA is always valid combinationally from the current registers. When BUSY, STALL=1 and the consumer must not use RD_DATA.
- Writes:
  - In IDLE with WR_EN=1 and START=0, the selected register takes WR_DATA at the edge; the other register is unchanged.
  - WR_EN while BUSY: the write is discarded and STALL=1.
  - START and WR_EN together in IDLE: START wins and the write is discarded (controller never issues both).
- DONE and a write in the same cycle: impossible by construction, since writes occur only in IDLE.
- Zero operands and -0 both produce HI=LO=0.

Test Plan:
- 7 x 6 unsigned -> HI=0x00000000, LO=0x0000002A; DONE pulses exactly 34 cycles after the START cycle; BUSY high for 33 cycles.
- SIGNED: -3 x 5 (A=0xFFFFFFFD, B=5) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; same inputs with SIGNED=0 -> HI=0x00000004, LO=0xFFFFFFF1.
- Extremes:
  - 0xFFFFFFFF x 0xFFFFFFFF unsigned -> HI=0xFFFFFFFE, LO=0x00000001.
  - 0x80000000 x 0x80000000 signed -> HI=0x40000000, LO=0x00000000.
  - 0x80000000 x 1 signed -> HI=0xFFFFFFFF, LO=0x80000000.
- Hazards:
  - RD_REQ=1 and RD_SEL=1 at cycle 10 of a multiply -> STALL=1 until BUSY drops; after DONE, RD_DATA = new HI.
  - A second START at cycle 5 is ignored; the result is unaffected.
  - WR_EN while busy is dropped and HI/LO reflect only the product.
- Writes in IDLE: write LO=0x12345678 then HI=0xDEADBEEF -> RD_DATA returns each value; simultaneous START+WR_EN -> product stored, write lost.
- Reset mid-operation: RESET at cycle 15 of RUN -> next cycle IDLE, BUSY=0, HI=LO=0, and no DONE pulse; a following 2 x 3 multiply yields LO=6.
